// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave state enum and size helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // Number of bytes moved by a transfer of the given hsize.
    function automatic logic [7:0] size_bytes(input logic [2:0] hsize);
        return 8'(1) << hsize;
    endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane strobes and misalignment flag from hsize and address LSBs.
module ahb_byte_strobe
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned LSB_W = $clog2(NB)
) (
    input  logic [2:0]       hsize,
    input  logic [LSB_W-1:0] addr_lsb,
    output logic [NB-1:0]    strb,
    output logic             misalign
);

    // Enable lanes [addr_lsb, addr_lsb+size) and flag any set address bit below the size.
    always_comb begin
        strb     = '0;
        misalign = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if ((b >= 32'(addr_lsb)) &&
                (b < (32'(addr_lsb) + 32'(size_bytes(hsize))))) begin
                strb[b] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < LSB_W; i++) begin
            if (addr_lsb[i] && (i < 32'(hsize))) begin
                misalign = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a flop-based word memory with wait states and ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        DEPTH     = 256,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        WAIT      = 0
) (
    input  logic              hclk,
    input  logic              hrst_n,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [3:0]        hprot,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int unsigned       NB      = DATA_W / 8;
    localparam int unsigned       LSB_W   = $clog2(NB);
    localparam int unsigned       IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(DEPTH * NB);
    localparam logic [3:0]        WAIT_LD = 4'(WAIT);

    slv_state_e        state_q;
    slv_state_e        state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              hreadyout_d;
    logic [1:0]        hresp_d;

    logic [ADDR_W-1:0] offset_c;
    logic [IDX_W-1:0]  idx_c;
    logic [NB-1:0]     strb_c;
    logic              misalign_c;
    logic              range_err_c;
    logic              size_err_c;
    logic              xfer_err_c;
    logic              can_accept_c;
    logic              accept_c;

    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [NB-1:0]     strb_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              unused_c;

    // Address-phase decode: offset into the window, word index and legality.
    assign offset_c     = haddr - BASE_ADDR;
    assign idx_c        = IDX_W'(offset_c >> LSB_W);
    assign range_err_c  = (offset_c >= SPAN);
    assign size_err_c   = (32'(hsize) > LSB_W);
    assign xfer_err_c   = range_err_c | size_err_c | misalign_c;
    assign can_accept_c = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept_c     = hsel & hready & htrans[1] & can_accept_c;
    assign unused_c     = ^{hprot, htrans[0]};

    ahb_byte_strobe #(
        .DATA_W (DATA_W)
    ) u_strobe (
        .hsize    (hsize),
        .addr_lsb (offset_c[LSB_W-1:0]),
        .strb     (strb_c),
        .misalign (misalign_c)
    );

    // Next-state, wait counter and next registered response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    if (xfer_err_c) begin
                        state_d = ST_ERR1;
                    end else if (WAIT != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d == ST_WAIT) || (state_d == ST_ERR1)) begin
            hreadyout_d = 1'b0;
        end
        if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
            hresp_d = HRESP_ERROR;
        end
    end

    // State, response and captured address-phase registers.
    always_ff @(posedge hclk) begin
        if (!hrst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hreadyout <= hreadyout_d;
            hresp     <= hresp_d;
            if (accept_c) begin
                wr_q   <= hwrite;
                idx_q  <= idx_c;
                strb_q <= strb_c;
            end
        end
    end

    // Commit write data under byte strobes at the end of the data phase; reset drops it.
    always_ff @(posedge hclk) begin
        if (hrst_n && (state_q == ST_DATA) && wr_q) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data only in a read data phase, zero otherwise.
    always_comb begin
        hrdata = '0;
        if ((state_q == ST_DATA) && !wr_q) begin
            hrdata = mem[idx_q];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave (WAIT=0, WAIT=2 and 64-bit instances).
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int TMO = 20;

    logic        hclk = 1'b0;
    logic        hrst_n;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [63:0] hwdata;
    int          cur;

    logic        hsel0, hsel2, hsel6;
    logic        ro0, ro2, ro6;
    logic [1:0]  rs0, rs2, rs6;
    logic [31:0] rd0, rd2;
    logic [63:0] rd6;

    logic        ro_m;
    logic [1:0]  rs_m;
    logic [63:0] rd_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 hclk = ~hclk;

    assign hsel0 = (cur == 0);
    assign hsel2 = (cur == 1);
    assign hsel6 = (cur == 2);

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT(0)) u_dut0 (
        .hclk(hclk), .hrst_n(hrst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata[31:0]),
        .hready(ro0), .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT(2)) u_dut2 (
        .hclk(hclk), .hrst_n(hrst_n), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata[31:0]),
        .hready(ro2), .hreadyout(ro2), .hresp(rs2), .hrdata(rd2));

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(64), .DEPTH(16), .BASE_ADDR(32'h0), .WAIT(0)) u_dut64 (
        .hclk(hclk), .hrst_n(hrst_n), .hsel(hsel6), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hready(ro6), .hreadyout(ro6), .hresp(rs6), .hrdata(rd6));

    // Response of the currently selected slave.
    always_comb begin
        case (cur)
            0:       begin ro_m = ro0; rs_m = rs0; rd_m = {32'h0, rd0}; end
            1:       begin ro_m = ro2; rs_m = rs2; rd_m = {32'h0, rd2}; end
            default: begin ro_m = ro6; rs_m = rs6; rd_m = rd6;          end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One NONSEQ transfer; entered and left #1 after a rising edge.
    task automatic xfer(input int dut, input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [63:0] wd, output logic [63:0] rd, output logic [1:0] r_first,
                        output logic [1:0] r_last, output int waits);
        bit done;
        int n;
        cur    = dut;
        haddr  = addr;
        hwrite = wr;
        hsize  = sz;
        htrans = HTRANS_NONSEQ;
        @(posedge hclk); #1;
        htrans  = HTRANS_IDLE;
        hwdata  = wd;
        waits   = 0;
        done    = 1'b0;
        n       = 0;
        rd      = '0;
        r_first = '0;
        r_last  = '0;
        while (!done && (n < TMO)) begin
            @(negedge hclk);
            if (n == 0) r_first = rs_m;
            if (ro_m) begin
                done   = 1'b1;
                r_last = rs_m;
                rd     = rd_m;
            end else begin
                waits++;
            end
            n++;
            @(posedge hclk); #1;
        end
        if (!done) check("xfer_timeout", 64'(done), 64'(1));
    endtask

    task automatic do_wr(input string tag, input int dut, input logic [31:0] addr,
                         input logic [2:0] sz, input logic [63:0] wd);
        logic [63:0] rd;
        logic [1:0]  r1, r2;
        int          wt;
        xfer(dut, 1'b1, addr, sz, wd, rd, r1, r2, wt);
        check({tag, "_wresp"}, 64'(r2), 64'(HRESP_OKAY));
    endtask

    task automatic rd_chk(input string tag, input int dut, input logic [31:0] addr,
                          input logic [2:0] sz, input logic [63:0] exp);
        logic [63:0] rd;
        logic [1:0]  r1, r2;
        int          wt;
        xfer(dut, 1'b0, addr, sz, '0, rd, r1, r2, wt);
        check({tag, "_data"}, rd, exp);
        check({tag, "_resp"}, 64'(r2), 64'(HRESP_OKAY));
    endtask

    task automatic err_chk(input string tag, input int dut, input logic wr, input logic [31:0] addr,
                           input logic [2:0] sz, input logic [63:0] wd);
        logic [63:0] rd;
        logic [1:0]  r1, r2;
        int          wt;
        xfer(dut, wr, addr, sz, wd, rd, r1, r2, wt);
        check({tag, "_waits"}, 64'(wt), 64'(1));
        check({tag, "_resp1"}, 64'(r1), 64'(HRESP_ERROR));
        check({tag, "_resp2"}, 64'(r2), 64'(HRESP_ERROR));
        check({tag, "_rdata"}, rd, 64'h0);
    endtask

    initial begin
        logic [63:0] rd;
        logic [1:0]  r1, r2;
        int          wt;

        cur    = 0;
        hrst_n = 1'b0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hprot  = 4'h3;
        hwdata = '0;
        repeat (2) @(posedge hclk);
        #1 hrst_n = 1'b1;
        @(negedge hclk);
        check("rst_ready0", 64'(ro0), 64'(1));
        check("rst_resp0",  64'(rs0), 64'(0));
        check("rst_rdata0", 64'(rd0), 64'(0));
        check("rst_ready2", 64'(ro2), 64'(1));
        check("rst_ready6", 64'(ro6), 64'(1));
        check("rst_rdata6", rd6, 64'(0));
        @(posedge hclk); #1;

        // Back-to-back word write then read of 0x10 with no wait states.
        cur = 0; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        @(posedge hclk); #1;
        hwdata = 64'hDEAD_BEEF; hwrite = 1'b0; haddr = 32'h10; htrans = HTRANS_NONSEQ;
        @(negedge hclk);
        check("b2b_wr_ready", 64'(ro_m), 64'(1));
        check("b2b_wr_resp",  64'(rs_m), 64'(0));
        @(posedge hclk); #1;
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("b2b_rd_ready", 64'(ro_m), 64'(1));
        check("b2b_rd_data",  rd_m, 64'hDEAD_BEEF);
        check("b2b_rd_resp",  64'(rs_m), 64'(0));
        @(posedge hclk); #1;
        @(negedge hclk);
        check("idle_rdata", rd_m, 64'h0);
        @(posedge hclk); #1;

        // Two wait states; a NONSEQ raised during the wait is held until hready.
        xfer(1, 1'b1, 32'h04, HSIZE_WORD, 64'h0BAD_F00D, rd, r1, r2, wt);
        check("w2_waits", 64'(wt), 64'(2));
        do_wr("w2_pre8", 1, 32'h08, HSIZE_WORD, 64'h5555_AAAA);
        haddr = 32'h04; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        @(posedge hclk); #1;
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("w2_wait1_ready", 64'(ro_m), 64'(0));
        check("w2_wait1_rdata", rd_m, 64'h0);
        @(posedge hclk); #1;
        htrans = HTRANS_NONSEQ; haddr = 32'h08;
        @(negedge hclk);
        check("w2_wait2_ready", 64'(ro_m), 64'(0));
        @(posedge hclk); #1;
        @(negedge hclk);
        check("w2_data_ready", 64'(ro_m), 64'(1));
        check("w2_data",       rd_m, 64'h0BAD_F00D);
        @(posedge hclk); #1;
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("w2_next_wait1", 64'(ro_m), 64'(0));
        @(posedge hclk); #1;
        @(negedge hclk);
        check("w2_next_wait2", 64'(ro_m), 64'(0));
        @(posedge hclk); #1;
        @(negedge hclk);
        check("w2_next_ready", 64'(ro_m), 64'(1));
        check("w2_next_data",  rd_m, 64'h5555_AAAA);
        @(posedge hclk); #1;

        // Byte and halfword lanes.
        do_wr("bs_clr", 0, 32'h10, HSIZE_WORD, 64'h0);
        do_wr("bs_b13", 0, 32'h13, HSIZE_BYTE, 64'hA500_0000);
        rd_chk("bs_rd1", 0, 32'h10, HSIZE_WORD, 64'hA500_0000);
        do_wr("bs_h12", 0, 32'h12, HSIZE_HALF, 64'h1234_0000);
        rd_chk("bs_rd2", 0, 32'h10, HSIZE_WORD, 64'h1234_0000);
        do_wr("bs_b11", 0, 32'h11, HSIZE_BYTE, 64'hFFFF_77FF);
        rd_chk("bs_rd3", 0, 32'h10, HSIZE_WORD, 64'h1234_7700);

        // Error responses and top-of-window boundary.
        do_wr("er_pre0", 0, 32'h00, HSIZE_WORD, 64'h1111_1111);
        err_chk("er_range", 0, 1'b0, 32'h400, HSIZE_WORD, 64'h0);
        err_chk("er_malgn", 0, 1'b1, 32'h01, HSIZE_HALF, 64'h00FF_FF00);
        rd_chk("er_after", 0, 32'h00, HSIZE_WORD, 64'h1111_1111);
        err_chk("er_size", 0, 1'b1, 32'h00, HSIZE_DWORD, 64'h2222_2222);
        rd_chk("er_after2", 0, 32'h00, HSIZE_WORD, 64'h1111_1111);
        do_wr("top_wr", 0, 32'h3FC, HSIZE_WORD, 64'h7E7E_0FF0);
        rd_chk("top_rd", 0, 32'h3FC, HSIZE_WORD, 64'h7E7E_0FF0);

        // Reset during the wait of a write drops it.
        do_wr("rw_pre", 1, 32'h20, HSIZE_WORD, 64'h2020_2020);
        cur = 1; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        @(posedge hclk); #1;
        htrans = HTRANS_IDLE; hwdata = 64'hFFFF_0000;
        @(negedge hclk);
        check("rw_wait_ready", 64'(ro_m), 64'(0));
        @(posedge hclk); #1;
        hrst_n = 1'b0;
        @(posedge hclk); #1;
        hrst_n = 1'b1;
        @(negedge hclk);
        check("rw_post_ready", 64'(ro_m), 64'(1));
        check("rw_post_resp",  64'(rs_m), 64'(0));
        check("rw_post_rdata", rd_m, 64'h0);
        @(posedge hclk); #1;
        rd_chk("rw_old", 1, 32'h20, HSIZE_WORD, 64'h2020_2020);

        // Reset at the committing edge of a zero-wait write drops it.
        do_wr("rd_pre", 0, 32'h24, HSIZE_WORD, 64'h2424_2424);
        cur = 0; haddr = 32'h24; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        @(posedge hclk); #1;
        htrans = HTRANS_IDLE; hwdata = 64'hDEAD_0000; hrst_n = 1'b0;
        @(posedge hclk); #1;
        hrst_n = 1'b1;
        @(posedge hclk); #1;
        rd_chk("rd_old", 0, 32'h24, HSIZE_WORD, 64'h2424_2424);

        // 64-bit instance, 16 words.
        do_wr("d64_wr", 2, 32'h78, HSIZE_DWORD, 64'h0123_4567_89AB_CDEF);
        rd_chk("d64_rd", 2, 32'h78, HSIZE_DWORD, 64'h0123_4567_89AB_CDEF);
        err_chk("d64_range", 2, 1'b0, 32'h80, HSIZE_DWORD, 64'h0);
        err_chk("d64_malgn", 2, 1'b1, 32'h04, HSIZE_DWORD, 64'hFFFF_FFFF_FFFF_FFFF);
        do_wr("d64_clr", 2, 32'h08, HSIZE_DWORD, 64'h0);
        do_wr("d64_hiw", 2, 32'h0C, HSIZE_WORD, 64'hAABB_CCDD_0000_0000);
        rd_chk("d64_lane", 2, 32'h08, HSIZE_DWORD, 64'hAABB_CCDD_0000_0000);
        rd_chk("d64_keep", 2, 32'h78, HSIZE_DWORD, 64'h0123_4567_89AB_CDEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
